vga_frame_capture: RTL and testbench

- Receive-side counterpart of the VGA timing/address generator: consumes a VGA-style stream (HS, VS, BLANK_n, 24-bit RGB) on the pixel clock.
- Recovers pixel coordinates, writes each active pixel into a 640x480 frame buffer (19-bit linear address), and checks frame geometry.
- Used for loopback self-test of the display path and for capturing an external video source into on-chip memory.

---
 rtl/vga_frame_capture.sv | 200 ++++++++++++++++++++
 tb/tb_vga_frame_capture.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_capture.sv
// VGA stream receiver: recovers pixel coordinates from BLANK_n/VS, writes active
// pixels to a linear frame buffer and grades each frame's geometry.
module vga_frame_capture #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned SYNC_TMO_W = 20
) (
    input  logic              iVGA_CLK,
    input  logic              iRST_n,
    input  logic              iHS,
    input  logic              iVS,
    input  logic              iBLANK_n,
    input  logic [23:0]       iRGB,
    output logic              oWR_EN,
    output logic [ADDR_W-1:0] oWR_ADDR,
    output logic [23:0]       oWR_DATA,
    output logic [9:0]        oX,
    output logic [9:0]        oY,
    output logic              oFRAME_DONE,
    output logic              oFRAME_OK,
    output logic              oLOCKED,
    output logic [7:0]        oERR_CNT
);
    localparam int unsigned CRD_W = 10;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned ERR_W = 8;
    localparam logic [CRD_W-1:0] CRD_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [CRD_W-1:0] H_LIM   = CRD_W'(H_ACTIVE);
    localparam logic [CRD_W-1:0] V_LIM   = CRD_W'(V_ACTIVE);

    typedef enum logic [1:0] {
        ST_HUNT        = 2'd0,
        ST_WAIT_ACTIVE = 2'd1,
        ST_CAPTURE     = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             hs_q, vs_q, den_q, vs_prev, den_prev;
    logic [PIX_W-1:0] rgb_q;
    logic             vs_fall, den_fall, sync_lost, frame_good;
    logic [SYNC_TMO_W:0] vs_hi_cnt;

    logic [CRD_W-1:0]  x_q, x_d, y_q, y_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              line_err_q, line_err_d;

    logic              wr_en_d, done_d, ok_d, locked_d;
    logic [ADDR_W-1:0] wr_addr_d;
    logic [PIX_W-1:0]  wr_data_d;
    logic [CRD_W-1:0]  x_out_d, y_out_d;
    logic [ERR_W-1:0]  err_d;

    // HS is registered with the rest of the stream; geometry is derived from BLANK_n and VS.
    logic unused_hs;
    assign unused_hs = hs_q;

    // Input stage plus one-sample history for edge detection
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            den_q    <= 1'b0;
            rgb_q    <= '0;
            vs_prev  <= 1'b0;
            den_prev <= 1'b0;
        end else begin
            hs_q     <= iHS;
            vs_q     <= iVS;
            den_q    <= iBLANK_n;
            rgb_q    <= iRGB;
            vs_prev  <= vs_q;
            den_prev <= den_q;
        end
    end

    assign vs_fall    = vs_prev & ~vs_q;
    assign den_fall   = den_prev & ~den_q;
    assign frame_good = (y_q == V_LIM) && !line_err_q;

    // Consecutive cycles with VS idle; top bit set means the frame period is exceeded
    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            vs_hi_cnt <= '0;
        end else if (!vs_q) begin
            vs_hi_cnt <= '0;
        end else if (!vs_hi_cnt[SYNC_TMO_W]) begin
            vs_hi_cnt <= vs_hi_cnt + (SYNC_TMO_W+1)'(1);
        end
    end

    assign sync_lost = vs_q && vs_hi_cnt[SYNC_TMO_W];

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) state_q <= ST_HUNT;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT:        if (vs_fall) state_d = ST_WAIT_ACTIVE;
            ST_WAIT_ACTIVE: if (!vs_fall && den_q) state_d = ST_CAPTURE;
            ST_CAPTURE: begin
                if (vs_fall)        state_d = ST_WAIT_ACTIVE;
                else if (sync_lost) state_d = ST_HUNT;
            end
            default:        state_d = ST_HUNT;
        endcase
    end

    // Coordinate tracking, write port and frame grading; frame end outranks a coincident pixel
    always_comb begin
        x_d        = x_q;
        y_d        = y_q;
        addr_d     = addr_q;
        line_err_d = line_err_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = oWR_ADDR;
        wr_data_d  = oWR_DATA;
        x_out_d    = oX;
        y_out_d    = oY;
        done_d     = 1'b0;
        ok_d       = oFRAME_OK;
        locked_d   = oLOCKED;
        err_d      = oERR_CNT;

        if (state_q == ST_HUNT) begin
            if (vs_fall) begin
                x_d        = '0;
                y_d        = '0;
                addr_d     = '0;
                line_err_d = 1'b0;
            end
        end else if (vs_fall) begin
            done_d   = 1'b1;
            ok_d     = frame_good;
            locked_d = frame_good;
            if (!frame_good && oERR_CNT != ERR_MAX) err_d = oERR_CNT + ERR_W'(1);
            x_d        = '0;
            y_d        = '0;
            addr_d     = '0;
            line_err_d = 1'b0;
        end else if (state_q == ST_CAPTURE && sync_lost) begin
            locked_d = 1'b0;
        end else if (den_q) begin
            if (x_q < H_LIM && y_q < V_LIM) begin
                wr_en_d   = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rgb_q;
                x_out_d   = x_q;
                y_out_d   = y_q;
                x_d       = x_q + CRD_W'(1);
                addr_d    = addr_q + ADDR_W'(1);
            end else begin
                line_err_d = 1'b1;
                if (x_q != CRD_MAX) x_d = x_q + CRD_W'(1);
            end
        end else if (den_fall && state_q == ST_CAPTURE) begin
            if (x_q != H_LIM) line_err_d = 1'b1;
            x_d = '0;
            if (y_q != CRD_MAX) y_d = y_q + CRD_W'(1);
        end
    end

    always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
        if (!iRST_n) begin
            x_q         <= '0;
            y_q         <= '0;
            addr_q      <= '0;
            line_err_q  <= 1'b0;
            oWR_EN      <= 1'b0;
            oWR_ADDR    <= '0;
            oWR_DATA    <= '0;
            oX          <= '0;
            oY          <= '0;
            oFRAME_DONE <= 1'b0;
            oFRAME_OK   <= 1'b0;
            oLOCKED     <= 1'b0;
            oERR_CNT    <= '0;
        end else begin
            x_q         <= x_d;
            y_q         <= y_d;
            addr_q      <= addr_d;
            line_err_q  <= line_err_d;
            oWR_EN      <= wr_en_d;
            oWR_ADDR    <= wr_addr_d;
            oWR_DATA    <= wr_data_d;
            oX          <= x_out_d;
            oY          <= y_out_d;
            oFRAME_DONE <= done_d;
            oFRAME_OK   <= ok_d;
            oLOCKED     <= locked_d;
            oERR_CNT    <= err_d;
        end
    end

endmodule

// File: tb/tb_vga_frame_capture.sv
// Directed bench for vga_frame_capture on a reduced 8x4 geometry.
`timescale 1ns/1ps
module tb_vga_frame_capture;
    localparam int unsigned H_ACTIVE   = 8;
    localparam int unsigned V_ACTIVE   = 4;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned SYNC_TMO_W = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              hs, vs, den;
    logic [23:0]       rgb;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [23:0]       wr_data;
    logic [9:0]        ox, oy;
    logic              done, ok, locked;
    logic [7:0]        err;

    vga_frame_capture #(
        .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ADDR_W(ADDR_W), .SYNC_TMO_W(SYNC_TMO_W)
    ) dut (
        .iVGA_CLK(clk), .iRST_n(rst_n), .iHS(hs), .iVS(vs), .iBLANK_n(den), .iRGB(rgb),
        .oWR_EN(wr_en), .oWR_ADDR(wr_addr), .oWR_DATA(wr_data), .oX(ox), .oY(oy),
        .oFRAME_DONE(done), .oFRAME_OK(ok), .oLOCKED(locked), .oERR_CNT(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [23:0]       data;
        logic [9:0]        x;
        logic [9:0]        y;
    } wr_t;
    typedef struct {
        logic       ok;
        logic       locked;
        logic [7:0] err;
    } dn_t;

    wr_t wr_q[$];
    dn_t dn_q[$];
    wr_t mon_w;
    dn_t mon_d;
    int n_checks = 0;
    int n_fail   = 0;
    logic [23:0] pix;

    // Log write strobes and frame reports away from the rising edge
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            mon_w.addr = wr_addr; mon_w.data = wr_data; mon_w.x = ox; mon_w.y = oy;
            wr_q.push_back(mon_w);
        end
        if (done === 1'b1) begin
            mon_d.ok = ok; mon_d.locked = locked; mon_d.err = err;
            dn_q.push_back(mon_d);
        end
    end

    task automatic cyc(input logic h, input logic v, input logic d, input logic [23:0] c);
        hs = h; vs = v; den = d; rgb = c;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b1, 1'b1, 1'b0, 24'h0);
    endtask

    task automatic vsync();
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        cyc(1'b1, 1'b0, 1'b0, 24'h0);
        idle(4);
    endtask

    task automatic px(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b1, 1'b1, 1'b1, pix);
            pix = pix + 24'd1;
        end
    endtask

    task automatic line_end();
        idle(2);
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        cyc(1'b0, 1'b1, 1'b0, 24'h0);
        idle(2);
    endtask

    task automatic line(input int n);
        px(n);
        line_end();
    endtask

    task automatic body(input int l0, input int l1, input int l2, input int l3);
        idle(12);
        line(l0); line(l1); line(l2); line(l3);
        idle(12);
    endtask

    task automatic clear_logs();
        wr_q.delete();
        dn_q.delete();
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        idle(3);
        clear_logs();
        pix = 24'd0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL reset_wr_en got %0b want 0", wr_en); end
        n_checks++; if (wr_addr !== '0) begin n_fail++; $display("FAIL reset_wr_addr got %0d want 0", wr_addr); end
        n_checks++; if (wr_data !== 24'h0) begin n_fail++; $display("FAIL reset_wr_data got %h want 0", wr_data); end
        n_checks++; if (ox !== 10'd0 || oy !== 10'd0) begin n_fail++; $display("FAIL reset_xy got %0d,%0d want 0,0", ox, oy); end
        n_checks++; if (done !== 1'b0 || ok !== 1'b0 || locked !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags got done=%0b ok=%0b locked=%0b want 0,0,0", done, ok, locked); end
        n_checks++; if (err !== 8'd0) begin n_fail++; $display("FAIL reset_err got %0d want 0", err); end
        rst_n = 1'b1;
        idle(3);
        clear_logs();
        pix = 24'd0;
        body(8, 8, 8, 8);
        n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL hunt_no_writes got %0d want 0", wr_q.size()); end
        n_checks++; if (dn_q.size() != 0) begin n_fail++; $display("FAIL hunt_no_done got %0d want 0", dn_q.size()); end
    endtask

    task automatic test_nominal();
        reset_dut();
        vsync();
        for (int f = 0; f < 2; f++) begin
            clear_logs();
            pix = 24'd0;
            body(8, 8, 8, 8);
            vsync();
            n_checks++; if (wr_q.size() != 32) begin n_fail++; $display("FAIL nom_count f%0d got %0d want 32", f, wr_q.size()); end
            for (int i = 0; i < wr_q.size() && i < 32; i++) begin
                n_checks++;
                if (wr_q[i].addr !== ADDR_W'(i) || wr_q[i].data !== 24'(i) ||
                    wr_q[i].x !== 10'(i % 8) || wr_q[i].y !== 10'(i / 8)) begin
                    n_fail++;
                    $display("FAIL nom_wr f%0d[%0d] got a=%0d d=%0d x=%0d y=%0d want a=%0d d=%0d x=%0d y=%0d",
                             f, i, wr_q[i].addr, wr_q[i].data, wr_q[i].x, wr_q[i].y, i, i, i % 8, i / 8);
                end
            end
            n_checks++; if (dn_q.size() != 1) begin n_fail++; $display("FAIL nom_done f%0d got %0d want 1", f, dn_q.size()); end
            else begin
                n_checks++;
                if (dn_q[0].ok !== 1'b1 || dn_q[0].locked !== 1'b1 || dn_q[0].err !== 8'd0) begin
                    n_fail++; $display("FAIL nom_status f%0d got ok=%0b lk=%0b err=%0d want 1,1,0",
                                       f, dn_q[0].ok, dn_q[0].locked, dn_q[0].err); end
            end
        end
    endtask

    task automatic test_latency();
        reset_dut();
        vsync();
        idle(12);
        hs = 1'b1; vs = 1'b1; den = 1'b1; rgb = 24'hA5A5A5;
        @(posedge clk); #1;
        n_checks++; if (wr_en !== 1'b0) begin n_fail++; $display("FAIL lat_early got wr_en=%0b want 0", wr_en); end
        rgb = 24'h5A5A5A;
        @(posedge clk); #1;
        n_checks++;
        if (wr_en !== 1'b1 || wr_data !== 24'hA5A5A5 || wr_addr !== '0 || ox !== 10'd0 || oy !== 10'd0) begin
            n_fail++; $display("FAIL lat_n2 got en=%0b d=%h a=%0d x=%0d y=%0d want 1 a5a5a5 0 0 0",
                               wr_en, wr_data, wr_addr, ox, oy); end
        pix = 24'd2;
        px(6);
        n_checks++;
        if (wr_q.size() < 2 || wr_q[1].data !== 24'h5A5A5A || wr_q[1].x !== 10'd1) begin
            n_fail++; $display("FAIL lat_second got n=%0d want entry1 d=5a5a5a x=1", wr_q.size()); end
        line_end();
        line(8); line(8); line(8);
        idle(12);
        vsync();
        n_checks++; if (dn_q.size() != 1 || dn_q[0].ok !== 1'b1) begin
            n_fail++; $display("FAIL lat_frame_ok got n=%0d want 1 ok frame", dn_q.size()); end
    endtask

    task automatic test_short_line();
        reset_dut();
        vsync();
        clear_logs();
        body(8, 8, 7, 8);
        vsync();
        n_checks++; if (wr_q.size() != 31) begin n_fail++; $display("FAIL short_count got %0d want 31", wr_q.size()); end
        n_checks++;
        if (wr_q.size() < 31 || wr_q[22].addr !== ADDR_W'(22) || wr_q[22].x !== 10'd6 || wr_q[22].y !== 10'd2 ||
            wr_q[23].addr !== ADDR_W'(23) || wr_q[23].x !== 10'd0 || wr_q[23].y !== 10'd3) begin
            n_fail++; $display("FAIL short_addr got n=%0d want [22]=22@(6,2) [23]=23@(0,3)", wr_q.size()); end
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b0 || dn_q[0].locked !== 1'b0 || dn_q[0].err !== 8'd1) begin
            n_fail++; $display("FAIL short_status got n=%0d ok=%0b lk=%0b err=%0d want 1,0,0,1",
                               dn_q.size(), ok, locked, err); end
        clear_logs();
        pix = 24'd0;
        body(8, 8, 8, 8);
        vsync();
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b1 || dn_q[0].locked !== 1'b1 || dn_q[0].err !== 8'd1) begin
            n_fail++; $display("FAIL short_recover got n=%0d ok=%0b lk=%0b err=%0d want 1,1,1,1",
                               dn_q.size(), ok, locked, err); end
    endtask

    task automatic test_long_line();
        reset_dut();
        vsync();
        clear_logs();
        body(10, 8, 8, 8);
        vsync();
        n_checks++; if (wr_q.size() != 32) begin n_fail++; $display("FAIL long_count got %0d want 32", wr_q.size()); end
        n_checks++;
        if (wr_q.size() < 32 || wr_q[7].addr !== ADDR_W'(7) || wr_q[7].data !== 24'd7 ||
            wr_q[8].addr !== ADDR_W'(8) || wr_q[8].data !== 24'd10 || wr_q[8].x !== 10'd0 || wr_q[8].y !== 10'd1 ||
            wr_q[31].addr !== ADDR_W'(31) || wr_q[31].data !== 24'd33) begin
            n_fail++; $display("FAIL long_addr got n=%0d want [7]=7/7 [8]=8/10@(0,1) [31]=31/33", wr_q.size()); end
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b0 || dn_q[0].err !== 8'd1) begin
            n_fail++; $display("FAIL long_status got n=%0d ok=%0b err=%0d want 1,0,1", dn_q.size(), ok, err); end
    endtask

    task automatic test_mid_frame_start();
        rst_n = 1'b0;
        clear_logs();
        pix = 24'd0;
        idle(12);
        line(8); line(8);
        px(3);
        rst_n = 1'b1;
        px(5);
        line_end();
        line(8);
        idle(12);
        n_checks++; if (wr_q.size() != 0) begin n_fail++; $display("FAIL midstart_writes got %0d want 0", wr_q.size()); end
        vsync();
        n_checks++; if (dn_q.size() != 0) begin n_fail++; $display("FAIL midstart_done got %0d want 0", dn_q.size()); end
        pix = 24'd0;
        body(8, 8, 8, 8);
        vsync();
        n_checks++;
        if (wr_q.size() != 32 || wr_q[31].addr !== ADDR_W'(31) || wr_q[31].data !== 24'd31) begin
            n_fail++; $display("FAIL midstart_frame got n=%0d want 32 ending at 31", wr_q.size()); end
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b1 || dn_q[0].locked !== 1'b1) begin
            n_fail++; $display("FAIL midstart_ok got n=%0d ok=%0b want 1 good frame", dn_q.size(), ok); end
    endtask

    task automatic test_reset_mid_line();
        reset_dut();
        vsync();
        body(8, 8, 8, 8);
        vsync();
        n_checks++; if (locked !== 1'b1 || ok !== 1'b1) begin
            n_fail++; $display("FAIL rml_pre got ok=%0b lk=%0b want 1,1", ok, locked); end
        pix = 24'h100;
        idle(12);
        px(4);
        rst_n = 1'b0;
        #2;
        n_checks++;
        if (wr_en !== 1'b0 || wr_addr !== '0 || wr_data !== 24'h0 || ox !== 10'd0 || oy !== 10'd0 ||
            done !== 1'b0 || ok !== 1'b0 || locked !== 1'b0 || err !== 8'd0) begin
            n_fail++; $display("FAIL rml_async got en=%0b a=%0d d=%h x=%0d ok=%0b lk=%0b want all 0",
                               wr_en, wr_addr, wr_data, ox, ok, locked); end
        clear_logs();
        px(2);
        rst_n = 1'b1;
        px(2);
        line_end();
        line(8); line(8); line(8);
        idle(12);
        vsync();
        n_checks++; if (wr_q.size() != 0 || dn_q.size() != 0) begin
            n_fail++; $display("FAIL rml_hunt got wr=%0d done=%0d want 0,0", wr_q.size(), dn_q.size()); end
        body(8, 8, 8, 8);
        vsync();
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b1 || dn_q[0].err !== 8'd0) begin
            n_fail++; $display("FAIL rml_recover got n=%0d ok=%0b err=%0d want 1,1,0", dn_q.size(), ok, err); end
    endtask

    task automatic test_sync_loss();
        reset_dut();
        vsync();
        body(8, 8, 8, 8);
        vsync();
        clear_logs();
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sl_pre got lk=%0b want 1", locked); end
        idle(12);
        line(8); line(8);
        idle(300);
        line(8);
        idle(12);
        n_checks++;
        if (locked !== 1'b0 || err !== 8'd0 || ok !== 1'b1) begin
            n_fail++; $display("FAIL sl_flags got lk=%0b err=%0d ok=%0b want 0,0,1", locked, err, ok); end
        n_checks++; if (wr_q.size() != 16) begin n_fail++; $display("FAIL sl_writes got %0d want 16", wr_q.size()); end
        vsync();
        n_checks++; if (dn_q.size() != 0) begin n_fail++; $display("FAIL sl_no_done got %0d want 0", dn_q.size()); end
        body(8, 8, 8, 8);
        vsync();
        n_checks++;
        if (dn_q.size() != 1 || dn_q[0].ok !== 1'b1 || dn_q[0].locked !== 1'b1) begin
            n_fail++; $display("FAIL sl_relock got n=%0d ok=%0b lk=%0b want 1,1,1", dn_q.size(), ok, locked); end
    endtask

    task automatic test_saturation();
        reset_dut();
        vsync();
        repeat (254) vsync();
        n_checks++; if (err !== 8'd254) begin n_fail++; $display("FAIL sat_254 got %0d want 254", err); end
        vsync();
        n_checks++; if (err !== 8'd255) begin n_fail++; $display("FAIL sat_255 got %0d want 255", err); end
        repeat (45) vsync();
        n_checks++; if (err !== 8'd255) begin n_fail++; $display("FAIL sat_hold got %0d want 255", err); end
        n_checks++; if (dn_q.size() != 300) begin n_fail++; $display("FAIL sat_done got %0d want 300", dn_q.size()); end
        n_checks++; if (ok !== 1'b0 || locked !== 1'b0) begin
            n_fail++; $display("FAIL sat_flags got ok=%0b lk=%0b want 0,0", ok, locked); end
    endtask

    initial begin
        rst_n = 1'b0;
        hs = 1'b1; vs = 1'b1; den = 1'b0; rgb = 24'h0;
        pix = 24'd0;
        test_reset();
        test_nominal();
        test_latency();
        test_short_line();
        test_long_line();
        test_mid_frame_start();
        test_reset_mid_line();
        test_sync_loss();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
